// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: shared DLFloat16 format constants, rounding modes and exception flag indices
package dlfloat_pkg;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_BIAS = 31;
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;
  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;
endpackage

// File: rtl/dlfloat16_int_rounder.sv
// dlfloat16_int_rounder: rounds an aligned magnitude to an integer and saturates it into the result range
module dlfloat16_int_rounder
  import dlfloat_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic             sign,
  input  logic             zero,
  input  logic             special,
  input  logic [31:0]      mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic [2:0]       rm,
  output logic [OUT_W-1:0] result,
  output logic [4:0]       flags
);
  localparam logic [32:0] POS_MAX = SIGNED_OUT ? (33'd1 << (OUT_W - 1)) - 33'd1 : (33'd1 << OUT_W) - 33'd1;
  localparam logic [32:0] NEG_MAX = SIGNED_OUT ? 33'd1 << (OUT_W - 1) : 33'd0;
  logic inc, ovf, nv, nx;
  logic [32:0] rmag;
  always_comb begin
    inc = rm == RM_RTZ ? 1'b0 :
          rm == RM_RDN ? sign & (guard | sticky) :
          rm == RM_RUP ? !sign & (guard | sticky) :
          rm == RM_RMM ? guard :
          guard & (sticky | mag[0]);
    rmag = {1'b0, mag} + {32'd0, inc};
    ovf = sign ? rmag > NEG_MAX : rmag > POS_MAX;
    nv = !zero & (special | ovf);
    nx = !zero & !nv & (guard | sticky);
    result = zero ? '0 :
             nv ? OUT_W'(sign ? NEG_MAX : POS_MAX) :
             sign ? OUT_W'(33'd0 - rmag) : OUT_W'(rmag);
    flags = '0;
    flags[NV] = nv;
    flags[NX] = nx;
  end
endmodule

// File: rtl/dlfloat16_to_int_pipe.sv
// dlfloat16_to_int_pipe: two-stage DLFloat16 to integer converter with valid/ready flow control and sticky flags
module dlfloat16_to_int_pipe
  import dlfloat_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter bit SIGNED_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      float_in,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] int_out,
  output logic [4:0]       exceptions,
  input  logic             flag_clr,
  output logic [4:0]       flags_sticky
);
  localparam int FRAC = DLF_BIAS + DLF_MAN_W;
  localparam int VW = 32 + FRAC;
  logic advance, s1_valid, s1_sign, s1_zero, s1_special, s1_guard, s1_sticky;
  logic [31:0] s1_mag;
  logic [2:0] s1_rm;
  logic [DLF_EXP_W-1:0] exp_f;
  logic [VW-1:0] aligned;
  logic [OUT_W-1:0] rnd_result;
  logic [4:0] rnd_flags;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign exp_f = float_in[DLF_MAN_W +: DLF_EXP_W];
  assign aligned = VW'({1'b1, float_in[DLF_MAN_W-1:0]}) << exp_f;
  dlfloat16_int_rounder #(.OUT_W(OUT_W), .SIGNED_OUT(SIGNED_OUT)) u_rounder (
    .sign(s1_sign),
    .zero(s1_zero),
    .special(s1_special),
    .mag(s1_mag),
    .guard(s1_guard),
    .sticky(s1_sticky),
    .rm(s1_rm),
    .result(rnd_result),
    .flags(rnd_flags)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_special <= 1'b0;
      s1_mag <= '0;
      s1_guard <= 1'b0;
      s1_sticky <= 1'b0;
      s1_rm <= '0;
      out_valid <= 1'b0;
      int_out <= '0;
      exceptions <= '0;
      flags_sticky <= '0;
    end else begin
      if (advance) begin
        s1_valid <= in_valid;
        s1_sign <= float_in[15];
        s1_zero <= exp_f == '0;
        s1_special <= &exp_f;
        s1_mag <= aligned[VW-1:FRAC];
        s1_guard <= aligned[FRAC-1];
        s1_sticky <= |aligned[FRAC-2:0];
        s1_rm <= rm;
        out_valid <= s1_valid;
        int_out <= rnd_result;
        exceptions <= rnd_flags;
      end
      if (out_valid && out_ready) flags_sticky <= (flag_clr ? 5'd0 : flags_sticky) | exceptions;
      else if (flag_clr) flags_sticky <= '0;
    end
  end
endmodule

// File: tb/tb_dlfloat16_to_int_pipe.sv
// tb_dlfloat16_to_int_pipe: directed self-checking bench for signed 32-bit and unsigned 8-bit converters
module tb_dlfloat16_to_int_pipe;
  typedef struct {
    logic [15:0] f;
    logic [2:0]  r;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;
  typedef struct {
    logic [15:0] f;
    logic [2:0]  r;
    logic [7:0]  res;
    logic [4:0]  fl;
  } uvec_t;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, flag_clr;
  logic [15:0] float_in;
  logic [2:0] rm;
  logic in_ready, out_valid;
  logic [31:0] int_out;
  logic [4:0] exceptions, flags_sticky;
  logic u_in_ready, u_out_valid;
  logic [7:0] u_int_out;
  logic [4:0] u_exc, u_sticky;
  int n_checks = 0;
  int n_fail = 0;
  vec_t round_vec [13] = '{
    '{16'h4080, 3'd0, 32'd2, 5'h01},
    '{16'h4080, 3'd3, 32'd3, 5'h01},
    '{16'h4080, 3'd1, 32'd2, 5'h01},
    '{16'h4080, 3'd4, 32'd3, 5'h01},
    '{16'h4080, 3'd2, 32'd2, 5'h01},
    '{16'hC080, 3'd0, 32'hFFFFFFFE, 5'h01},
    '{16'hC080, 3'd2, 32'hFFFFFFFD, 5'h01},
    '{16'hC080, 3'd3, 32'hFFFFFFFE, 5'h01},
    '{16'h3F00, 3'd0, 32'd2, 5'h01},
    '{16'h3E00, 3'd0, 32'd1, 5'h00},
    '{16'h4080, 3'd7, 32'd2, 5'h01},
    '{16'h3F00, 3'd5, 32'd2, 5'h01},
    '{16'h4180, 3'd0, 32'd4, 5'h01}
  };
  vec_t sat_vec [7] = '{
    '{16'h7C00, 3'd0, 32'h7FFFFFFF, 5'h10},
    '{16'hFC00, 3'd0, 32'h80000000, 5'h00},
    '{16'h7E00, 3'd0, 32'h7FFFFFFF, 5'h10},
    '{16'h0000, 3'd0, 32'h00000000, 5'h00},
    '{16'h01FF, 3'd0, 32'h00000000, 5'h00},
    '{16'hFE00, 3'd0, 32'h80000000, 5'h10},
    '{16'h7A00, 3'd0, 32'h40000000, 5'h00}
  };
  uvec_t uns_vec [6] = '{
    '{16'hC080, 3'd0, 8'h00, 5'h10},
    '{16'hBC00, 3'd0, 8'h00, 5'h01},
    '{16'h4E00, 3'd0, 8'hFF, 5'h10},
    '{16'h4DFC, 3'd0, 8'hFF, 5'h00},
    '{16'h4080, 3'd0, 8'h02, 5'h01},
    '{16'hBC00, 3'd2, 8'h00, 5'h10}
  };
  logic [15:0] b2b_f [10] = '{16'h3E00, 16'h4080, 16'h3F00, 16'hC080, 16'h7C00,
                              16'hFC00, 16'h0000, 16'h7E00, 16'hBC00, 16'h4100};
  logic [31:0] b2b_e [10] = '{32'd1, 32'd2, 32'd2, 32'hFFFFFFFE, 32'h7FFFFFFF,
                              32'h80000000, 32'd0, 32'h7FFFFFFF, 32'd0, 32'd3};
  dlfloat16_to_int_pipe #(.OUT_W(32), .SIGNED_OUT(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .float_in(float_in),
    .rm(rm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .int_out(int_out),
    .exceptions(exceptions),
    .flag_clr(flag_clr),
    .flags_sticky(flags_sticky)
  );
  dlfloat16_to_int_pipe #(.OUT_W(8), .SIGNED_OUT(1'b0)) dut_u (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(u_in_ready),
    .float_in(float_in),
    .rm(rm),
    .out_valid(u_out_valid),
    .out_ready(out_ready),
    .int_out(u_int_out),
    .exceptions(u_exc),
    .flag_clr(flag_clr),
    .flags_sticky(u_sticky)
  );
  always #5 clk = ~clk;
  task automatic xfer(input logic [15:0] f, input logic [2:0] r);
    @(negedge clk);
    float_in = f;
    rm = r;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5 && out_valid !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL xfer_timeout f=%h out_valid=%b required 1", f, out_valid);
    end
  endtask
  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || int_out !== 32'd0 || exceptions !== 5'd0 || flags_sticky !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b rdy=%b int=%h exc=%h sticky=%h required 0 1 0 0 0", out_valid, in_ready, int_out, exceptions, flags_sticky);
    end
    n_checks++;
    if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1 || u_int_out !== 8'd0 || u_sticky !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state_unsigned got v=%b rdy=%b int=%h sticky=%h required 0 1 0 0", u_out_valid, u_in_ready, u_int_out, u_sticky);
    end
  endtask
  task automatic test_latency();
    @(negedge clk);
    float_in = 16'h3E00;
    rm = 3'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early out_valid=%b required 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || int_out !== 32'd1 || exceptions !== 5'h00) begin
      n_fail++;
      $display("FAIL latency_two got v=%b int=%h exc=%h required 1 00000001 00", out_valid, int_out, exceptions);
    end
  endtask
  task automatic test_rounding();
    foreach (round_vec[i]) begin
      xfer(round_vec[i].f, round_vec[i].r);
      n_checks++;
      if (int_out !== round_vec[i].res || exceptions !== round_vec[i].fl) begin
        n_fail++;
        $display("FAIL round_%0d f=%h rm=%0d got %h/%h required %h/%h", i, round_vec[i].f, round_vec[i].r, int_out, exceptions, round_vec[i].res, round_vec[i].fl);
      end
    end
  endtask
  task automatic test_saturation();
    foreach (sat_vec[i]) begin
      xfer(sat_vec[i].f, sat_vec[i].r);
      n_checks++;
      if (int_out !== sat_vec[i].res || exceptions !== sat_vec[i].fl) begin
        n_fail++;
        $display("FAIL sat_%0d f=%h got %h/%h required %h/%h", i, sat_vec[i].f, int_out, exceptions, sat_vec[i].res, sat_vec[i].fl);
      end
    end
  endtask
  task automatic test_unsigned();
    foreach (uns_vec[i]) begin
      xfer(uns_vec[i].f, uns_vec[i].r);
      n_checks++;
      if (u_out_valid !== 1'b1 || u_int_out !== uns_vec[i].res || u_exc !== uns_vec[i].fl) begin
        n_fail++;
        $display("FAIL unsigned_%0d f=%h rm=%0d got v=%b %h/%h required 1 %h/%h", i, uns_vec[i].f, uns_vec[i].r, u_out_valid, u_int_out, u_exc, uns_vec[i].res, uns_vec[i].fl);
      end
    end
  endtask
  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    rm = 3'd0;
    while (got < 10 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || int_out !== held) begin
          n_fail++;
          $display("FAIL b2b_hold got v=%b int=%h required 1 %h", out_valid, int_out, held);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid = sent < 10;
      float_in = sent < 10 ? b2b_f[sent] : 16'h0000;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (int_out !== b2b_e[got]) begin
          n_fail++;
          $display("FAIL b2b_result_%0d got %h required %h", got, int_out, b2b_e[got]);
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = int_out;
      if (in_valid && in_ready) sent++;
    end
    n_checks++;
    if (got != 10) begin
      n_fail++;
      $display("FAIL b2b_count got %0d required 10", got);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_extra out_valid=%b required 0", out_valid);
      end
    end
  endtask
  task automatic test_sticky();
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_checks++;
    if (flags_sticky !== 5'h00) begin
      n_fail++;
      $display("FAIL sticky_clear got %h required 00", flags_sticky);
    end
    xfer(16'h7E00, 3'd0);
    xfer(16'h4080, 3'd0);
    @(negedge clk);
    n_checks++;
    if (flags_sticky !== 5'h11) begin
      n_fail++;
      $display("FAIL sticky_accum got %h required 11", flags_sticky);
    end
    xfer(16'h7E00, 3'd0);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_checks++;
    if (flags_sticky !== 5'h10) begin
      n_fail++;
      $display("FAIL sticky_clr_handshake got %h required 10", flags_sticky);
    end
  endtask
  task automatic test_reset_midstream();
    @(negedge clk);
    float_in = 16'h4080;
    rm = 3'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midstream_valid out_valid=%b required 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || int_out !== 32'd0 || exceptions !== 5'd0 || flags_sticky !== 5'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got v=%b int=%h exc=%h sticky=%h rdy=%b required 0 0 0 0 1", out_valid, int_out, exceptions, flags_sticky, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_after_reset out_valid=%b required 0", out_valid);
      end
    end
    xfer(16'h4100, 3'd0);
    n_checks++;
    if (int_out !== 32'd3 || exceptions !== 5'h00) begin
      n_fail++;
      $display("FAIL post_reset_result got %h/%h required 00000003/00", int_out, exceptions);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flag_clr = 1'b0;
    float_in = 16'h0000;
    rm = 3'd0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_latency();
    test_rounding();
    test_saturation();
    test_unsigned();
    test_back_to_back();
    test_sticky();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dlfloat16_to_int_pipe.md
DLFLOAT16_TO_INT_PIPE -- requirements
Module: dlfloat16_to_int_pipe

Interface
REQ-001 Parameter OUT_W, default 32, integer result width; legal range 8..32.
REQ-002 Parameter SIGNED_OUT, default 1, selects two's-complement (1) or unsigned (0) result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  input word and rm present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 float_in  input  16  DLFloat16 operand: sign [15], exponent [14:9] with bias 31, fraction [8:0] with hidden 1.
REQ-008 rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; values 5-7 are treated as RNE.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 int_out  output  OUT_W  converted integer.
REQ-012 exceptions  output  5  per-result flags {NV, DZ, OF, UF, NX}; DZ, OF and UF are always 0.
REQ-013 flag_clr  input  1  clears the sticky flag register.
REQ-014 flags_sticky  output  5  OR of exceptions over all completed output handshakes since the last clear.

Function
REQ-015 Two-stage pipeline: S1 registers decode/alignment (integer part, guard bit, sticky bit); S2 registers the rounded/saturated result and flags.
REQ-016 advance = !out_valid || out_ready; in_ready = advance; both stages load only when advance = 1 (global stall).
REQ-017 Latency is exactly 2 cycles from the accepting handshake to out_valid with out_ready held high; throughput is 1 result/cycle.
REQ-018 While out_valid = 1 and out_ready = 0, int_out, exceptions and out_valid are held stable.
REQ-019 Exponent 0 yields result 0 with flags 0, regardless of fraction.
REQ-020 Exponent 63 (Inf/NaN) yields saturation toward the sign (positive max for sign 0, negative min for sign 1, or 0 when unsigned) with NV = 1.
REQ-021 Otherwise, value = 1.f x 2^(exp-31); round to integer per rm using guard/sticky; NX = 1 iff any discarded bit is nonzero.
REQ-022 Signed range is [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned range is [0, 2^OUT_W-1].
REQ-023 A rounded magnitude outside the range saturates to the nearest bound, sets NV = 1 and clears NX.
REQ-024 Unsigned mode: a negative input rounding to 0 gives 0 (NX as per REQ-021); a negative input rounding to -1 or below gives 0 with NV = 1.
REQ-025 Exactly -2^(OUT_W-1) in signed mode is representable: no saturation, no flags.
REQ-026 flags_sticky |= exceptions on each out_valid && out_ready cycle.
REQ-027 When flag_clr coincides with a handshake, flags_sticky takes only the new result's flags.

Reset
REQ-028 Asserting rst clears both stage valid bits, int_out, exceptions and flags_sticky to 0 immediately, independent of clk.
REQ-029 In-flight data is discarded on reset; the first post-reset result requires a fresh input handshake.
REQ-030 in_ready is 1 during and after reset.

Structure
REQ-031 Shared package dlfloat_pkg holds: DLF_EXP_W = 6, DLF_MAN_W = 9, DLF_BIAS = 31, the rounding-mode enum, and the flag bit indices NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0.
REQ-032 S2 rounding/saturation logic is the combinational sub-module dlfloat16_int_rounder, parametrised by OUT_W and SIGNED_OUT.

Verification
REQ-033 Defaults, float_in = 0x4080 (2.5): RNE -> 2, NX = 1; RUP -> 3; RTZ -> 2; RMM -> 3.
REQ-034 float_in = 0xC080 (-2.5): RNE -> -2, RDN -> -3; 0x3F00 (1.5) RNE -> 2; 0x3E00 (1.0) -> 1, flags 0.
REQ-035 OUT_W = 32, signed: 0x7C00 -> 0x7FFFFFFF, NV = 1; 0xFC00 -> 0x80000000, flags 0; 0x7E00 -> 0x7FFFFFFF, NV = 1; 0x0000 -> 0, flags 0.
REQ-036 OUT_W = 8, SIGNED_OUT = 0: 0xC080 -> 0, NV = 1; 0xBC00 (-0.5) RNE -> 0, NX = 1, NV = 0; 2^8 input -> 0xFF, NV = 1.
REQ-037 Back-to-back stream of 10 inputs with out_ready toggled pseudo-randomly -> results in order, none lost or duplicated, outputs stable while stalled.
REQ-038 Sticky flags and reset: accumulate NV then NX -> flags_sticky = 0x11; flag_clr together with a handshake -> only the new flags remain; rst asserted mid-stream -> out_valid = 0 immediately and no stale result afterwards.
